// File: rtl/hs_pkg.sv
// Shared definitions for the handshake arbiter: FSM state encoding,
// the requester ceiling and a small modular-increment helper.
package hs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } hs_state_t;

  localparam int HS_MAX_REQ = 8;

  // Returns (a + b) mod n as a 3-bit requester index; a is always below n.
  function automatic logic [2:0] hs_mod_add(input logic [2:0] a, input int b, input int n);
    int t;
    t = (int'(a) + b) % n;
    return 3'(t);
  endfunction

endpackage

// File: rtl/hs_arb_run_if.sv
// Bundle of the upstream requester handshakes, the shared downstream
// handshake and the arbiter status outputs.
interface hs_arb_run_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  logic [N-1:0]    req;
  logic [N-1:0]    ack;
  logic [N*DW-1:0] data_in;
  logic            m_req;
  logic            m_ack;
  logic [DW-1:0]   m_data;
  logic [2:0]      grant_id;
  logic            busy;
  logic [31:0]     txn_count;

  // Environment side: requesters and the downstream engine.
  modport master (
    output req, data_in, m_ack,
    input  ack, m_req, m_data, grant_id, busy, txn_count
  );

  // Arbiter side.
  modport slave (
    input  req, data_in, m_ack,
    output ack, m_req, m_data, grant_id, busy, txn_count
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the
// pointer sits at bit 0, priority-encode the lowest set bit, then rotate
// the index back into requester numbering.
module rr_pick
  import hs_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [2:0]   i_ptr,
  output logic         o_valid,
  output logic [2:0]   o_idx
);

  logic [HS_MAX_REQ-1:0] w_reqPad;
  logic [N-1:0]          w_rot;
  logic [2:0]            w_enc;
  logic                  w_any;

  assign w_reqPad = HS_MAX_REQ'(i_req);

  // Rotate so that requester i_ptr lands in position 0.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++) begin
      w_rot[j] = w_reqPad[hs_mod_add(i_ptr, j, N)];
    end
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_any = 1'b0;
    w_enc = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any = 1'b1;
        w_enc = 3'(j);
      end
    end
  end

  assign o_valid = w_any;
  assign o_idx   = hs_mod_add(i_ptr, int'(w_enc), N);

endmodule

// File: rtl/hs_arb_run.sv
// Round-robin arbiter sharing one four-phase downstream handshake among
// N four-phase requesters; the winner's word is forwarded downstream and
// the downstream acknowledge is reflected back as the winner's ack.
module hs_arb_run
  import hs_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input logic          i_clk,
  input logic          i_rst,
  hs_arb_run_if.slave  io_bus
);

  hs_state_t             r_state;
  logic [2:0]            r_ptr;
  logic [2:0]            r_grantId;
  logic                  r_mReq;
  logic [N-1:0]          r_ack;
  logic                  r_busy;
  logic [31:0]           r_txnCount;

  logic                  w_pickValid;
  logic [2:0]            w_pickIdx;
  logic [HS_MAX_REQ-1:0] w_reqPad;
  logic [N-1:0]          w_grantOneHot;
  logic                  w_done;
  logic [DW-1:0]         w_mData;

  rr_pick #(.N(N)) u_pick (
    .i_req   (io_bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  assign w_reqPad = HS_MAX_REQ'(io_bus.req);
  assign w_done   = (r_state == S_ACK) && !w_reqPad[r_grantId] && !io_bus.m_ack;

  // One-hot of the latched winner, used to load the ack register.
  always_comb begin
    w_grantOneHot = '0;
    for (int i = 0; i < N; i++) begin
      w_grantOneHot[i] = (r_grantId == 3'(i));
    end
  end

  // Arbitration FSM; m_req/ack/busy are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_grantId <= '0;
      r_mReq    <= 1'b0;
      r_ack     <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pickValid) begin
            r_state   <= S_REQ;
            r_grantId <= w_pickIdx;
            r_mReq    <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_REQ: begin
          if (io_bus.m_ack) begin
            r_state <= S_ACK;
            r_mReq  <= 1'b0;
            r_ack   <= w_grantOneHot;
          end
        end
        S_ACK: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= hs_mod_add(r_grantId, 1, N);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mReq  <= 1'b0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Completed-transaction counter; rewritten every cycle and wraps freely.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_txnCount <= '0;
    end else begin
      r_txnCount <= r_txnCount + {31'b0, w_done};
    end
  end

  // Forward the winner's word only while the downstream request is up.
  always_comb begin
    w_mData = '0;
    for (int i = 0; i < N; i++) begin
      if ((r_state == S_REQ) && (r_grantId == 3'(i))) begin
        w_mData = io_bus.data_in[i*DW +: DW];
      end
    end
  end

  assign io_bus.m_req     = r_mReq;
  assign io_bus.ack       = r_ack;
  assign io_bus.busy      = r_busy;
  assign io_bus.grant_id  = r_grantId;
  assign io_bus.m_data    = w_mData;
  assign io_bus.txn_count = r_txnCount;

endmodule

// File: tb/tb_hs_arb_run.sv
// Self-checking bench for hs_arb_run: behavioural requesters and a
// downstream responder, a cycle model feeding a grant scoreboard, and
// directed checks for the arbitration scenarios.
module tb_hs_arb_run;
  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    int          grant;
    logic [31:0] data;
  } sb_entry_t;

  logic clk;
  logic rst;

  hs_arb_run_if #(.N(N), .DW(DW)) bus ();

  hs_arb_run #(.N(N), .DW(DW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          pending[N];
  logic        earlyDrop[N];
  logic [31:0] nextData[N];
  int          ackDelay = 1;
  int          waitCnt = 0;

  int          mState = 0;
  int          mGrant = 0;
  int          mPtr = 0;
  logic [31:0] mCount = '0;
  sb_entry_t   sbQ[$];
  int          grantLog[$];
  logic [31:0] dataLog[$];
  int          ack1Cycles = 0;
  logic        prevMreq = 1'b0;
  logic        finished = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input int count);
    pending[idx] = count;
  endtask

  function automatic int pendingTotal();
    int s = 0;
    for (int i = 0; i < N; i++) s += pending[i];
    return s;
  endfunction

  task automatic waitIdle(input string tag, input int maxCycles);
    logic done = 1'b0;
    for (int c = 0; c < maxCycles && !done; c++) begin
      @(negedge clk);
      if (pendingTotal() == 0 && bus.req == '0 && !bus.busy && !bus.m_ack) done = 1'b1;
    end
    checkOutput({tag, "Idle"}, {31'b0, done}, 32'd1);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Four-phase requesters: raise req with a word, drop it on ack, wait for ack low.
  initial begin
    bus.req     = '0;
    bus.data_in = '0;
    for (int i = 0; i < N; i++) begin
      pending[i]   = 0;
      earlyDrop[i] = 1'b0;
      nextData[i]  = $urandom;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i]) begin
          if (bus.ack[i] || (earlyDrop[i] && bus.m_req && bus.grant_id == 3'(i))) begin
            bus.req[i]   = 1'b0;
            earlyDrop[i] = 1'b0;
            if (pending[i] > 0) pending[i]--;
          end
        end else if (!bus.ack[i] && pending[i] > 0) begin
          bus.req[i]              = 1'b1;
          bus.data_in[i*DW +: DW] = nextData[i];
          nextData[i]             = $urandom;
        end
      end
    end
  end

  // Downstream engine: ack after ackDelay cycles of m_req, release once m_req falls.
  initial begin
    bus.m_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.m_req && !bus.m_ack) begin
        waitCnt++;
        if (waitCnt >= ackDelay) bus.m_ack = 1'b1;
      end else if (!bus.m_req && bus.m_ack) begin
        bus.m_ack = 1'b0;
        waitCnt   = 0;
      end else if (!bus.m_req) begin
        waitCnt = 0;
      end
    end
  end

  // Reference model stepped on the same edge as the DUT from bench-driven inputs.
  initial begin
    logic found;
    int   cand;
    forever begin
      @(posedge clk);
      if (rst) begin
        mState = 0;
        mPtr   = 0;
        mGrant = 0;
        mCount = '0;
      end else begin
        case (mState)
          0: begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
              cand = (mPtr + k) % N;
              if (!found && bus.req[cand]) begin
                found  = 1'b1;
                mGrant = cand;
              end
            end
            if (found) begin
              mState = 1;
              sbQ.push_back('{grant: mGrant, data: bus.data_in[mGrant*DW +: DW]});
            end
          end
          1: if (bus.m_ack) mState = 2;
          default: begin
            if (!bus.req[mGrant] && !bus.m_ack) begin
              mState = 0;
              mPtr   = (mGrant + 1) % N;
              mCount = mCount + 1;
            end
          end
        endcase
      end
    end
  end

  // Per-cycle output check against the model, plus scoreboard pop on each grant.
  initial begin
    sb_entry_t e;
    logic [N-1:0]  expAck;
    logic [DW-1:0] expData;
    forever begin
      @(posedge clk);
      #1;
      expAck  = (mState == 2) ? N'(1 << mGrant) : '0;
      expData = (mState == 1) ? bus.data_in[mGrant*DW +: DW] : '0;
      checkOutput("ack", 32'(bus.ack), 32'(expAck));
      checkOutput("mReq", {31'b0, bus.m_req}, {31'b0, mState == 1});
      checkOutput("busy", {31'b0, bus.busy}, {31'b0, mState != 0});
      checkOutput("mData", bus.m_data, expData);
      checkOutput("txnCount", bus.txn_count, mCount);
      checkOutput("ackOneHot", {31'b0, $countones(bus.ack) <= 1}, 32'd1);
      if (bus.m_req && !prevMreq) begin
        checkOutput("sbDepth", 32'(sbQ.size()), 32'd1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkOutput("sbGrant", 32'(bus.grant_id), 32'(e.grant));
          checkOutput("sbData", bus.m_data, e.data);
        end
        grantLog.push_back(int'(bus.grant_id));
        dataLog.push_back(bus.m_data);
      end
      if (!bus.m_req && prevMreq && !rst) begin
        checkOutput("mReqHold", {31'b0, bus.m_ack}, 32'd1);
      end
      if (bus.ack[1]) ack1Cycles++;
      prevMreq = bus.m_req;
    end
  end

  initial begin
    #400000;
    checkOutput("watchdog", {31'b0, finished}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int pos3;
    int cnt3;
    int expOrder[5] = '{0, 1, 2, 3, 0};
    logic seen;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstMReq", {31'b0, bus.m_req}, 32'd0);
    checkOutput("rstAck", 32'(bus.ack), 32'd0);
    checkOutput("rstBusy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rstMData", bus.m_data, 32'd0);
    checkOutput("rstGrant", 32'(bus.grant_id), 32'd0);
    checkOutput("rstTxn", bus.txn_count, 32'd0);
    rst = 1'b0;

    $display("[TB] single requester");
    ackDelay = 2;
    grantLog.delete();
    dataLog.delete();
    nextData[2] = 32'hDEADBEEF;
    applyStimulus(2, 1);
    waitIdle("single", 100);
    checkOutput("singleGrant", grantLog.size() > 0 ? grantLog[0] : 7, 32'd2);
    checkOutput("singleData", dataLog.size() > 0 ? dataLog[0] : 32'h0, 32'hDEADBEEF);
    checkOutput("singleTxn", bus.txn_count, 32'd1);

    $display("[TB] simultaneous requests");
    applyReset();
    ackDelay = 1;
    grantLog.delete();
    for (int i = 0; i < N; i++) applyStimulus(i, 2);
    waitIdle("simul", 300);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("order%0d", k), grantLog.size() > k ? grantLog[k] : 7, expOrder[k]);
    end

    $display("[TB] fairness");
    applyReset();
    grantLog.delete();
    applyStimulus(0, 5);
    applyStimulus(3, 1);
    waitIdle("fair", 300);
    pos3 = 99;
    cnt3 = 0;
    for (int k = 0; k < grantLog.size(); k++) begin
      if (grantLog[k] == 3) begin
        cnt3++;
        if (pos3 == 99) pos3 = k;
      end
    end
    checkOutput("fairWithin2", {31'b0, pos3 <= 1}, 32'd1);
    checkOutput("fairServed", cnt3, 32'd1);

    $display("[TB] early drop");
    ackDelay   = 3;
    ack1Cycles = 0;
    grantLog.delete();
    earlyDrop[1] = 1'b1;
    applyStimulus(1, 1);
    waitIdle("early", 100);
    checkOutput("earlyGrant", grantLog.size() > 0 ? grantLog[0] : 7, 32'd1);
    checkOutput("earlyAckPulse", {31'b0, ack1Cycles > 0}, 32'd1);

    $display("[TB] reset mid-op");
    ackDelay = 1;
    applyStimulus(2, 1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.ack != '0) seen = 1'b1;
    end
    checkOutput("rmAckSeen", {31'b0, seen}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rmAck", 32'(bus.ack), 32'd0);
    checkOutput("rmMReq", {31'b0, bus.m_req}, 32'd0);
    checkOutput("rmBusy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rmTxn", bus.txn_count, 32'd0);
    @(negedge clk);
    grantLog.delete();
    applyStimulus(0, 1);
    applyStimulus(2, 1);
    @(negedge clk);
    rst = 1'b0;
    waitIdle("rm", 200);
    checkOutput("rmFirstGrant", grantLog.size() > 0 ? grantLog[0] : 7, 32'd0);

    $display("[TB] counter wrap");
    @(negedge clk);
    force dut.r_txnCount = 32'hFFFF_FFFF;
    mCount = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.r_txnCount;
    @(negedge clk);
    checkOutput("wrapPreset", bus.txn_count, 32'hFFFF_FFFF);
    applyStimulus(3, 1);
    waitIdle("wrap", 100);
    checkOutput("wrapTxn", bus.txn_count, 32'd0);

    repeat (3) @(negedge clk);
    finished = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_arb_run.md
# hs_arb_run

Round-robin arbiter that shares one downstream req/ack handshake port, typically driving a single run/done adapter, among N upstream requesters that each use four-phase req/ack handshakes. The arbiter latches one winner and presents that winner's 32-bit word downstream. It completes the downstream handshake and reflects it back to the winner as that requester's ack. It sits between the command/register decoders and a shared run/done engine.

## Interface
- `N`, default 4: number of requesters, legal range 2..8.
- `DW`, default 32: data width per requester.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N  per-requester request; each requester holds its data stable while its req is high.
- `ack`  out  N  per-requester acknowledge; one-hot or zero.
- `data_in`  in  N*DW  requester data; requester i occupies bits [i*DW +: DW].
- `m_req`  out  1  downstream request.
- `m_ack`  in  1  downstream acknowledge, four-phase.
- `m_data`  out  DW  granted requester's data.
- `grant_id`  out  3  index of the current winner.
- `busy`  out  1  transaction in progress.
- `txn_count`  out  32  count of completed transactions.

## Operation
- The FSM has three states: S_IDLE, S_REQ and S_ACK.
- **S_IDLE:**
  - If `req` is nonzero, pick a winner by round-robin starting at `ptr`.
  - Register the winner into `grant_id` and go to S_REQ.
- **S_REQ:**
  - `m_req`=1.
  - `m_data` = `data_in[grant_id]`.
  - When `m_ack`=1, go to S_ACK.
- **S_ACK:**
  - `m_req`=0 and `ack[grant_id]`=1.
  - When `req[grant_id]`=0 and `m_ack`=0 in the same cycle:
    - go to S_IDLE;
    - set `ptr` to (`grant_id`+1) mod N;
    - increment `txn_count`, which wraps from 0xFFFFFFFF to 0.
- Output decoding:
  - `m_req` = (fsm==S_REQ).
  - `ack` = (fsm==S_ACK) ? one-hot(`grant_id`) : 0.
  - `busy` = (fsm!=S_IDLE).
  - `m_data` is 0 outside S_REQ.
- Round-robin search order is `ptr`, `ptr`+1, …, `ptr`+N-1, taken mod N; the first set bit wins.
- `grant_id` holds its value through S_REQ and S_ACK. It updates only on the S_IDLE→S_REQ transition.
- Once S_REQ is entered, a transaction is never cancelled.
  - If the winner drops `req` early, `m_req` stays high until `m_ack` arrives.
  - S_ACK then completes as soon as `m_ack` falls.
- Requests arriving while `busy` are ignored until the FSM returns to S_IDLE. No queuing beyond the level-held `req`.
- An unreachable state code goes to S_IDLE.

## Timing
- **Reset:**
  - fsm=S_IDLE, `ptr`=0, `grant_id`=0, `txn_count`=0.
  - Outputs are therefore `m_req`=0, `ack`=0, `busy`=0, `m_data`=0.
  - A reset asserted mid-transaction drops `m_req` and `ack` on the next edge. Downstream recovery is the downstream block's own reset.
- **Latencies:**
  - Arbitration latency is 1 cycle: `req` is high at edge k, and `m_req` is high after edge k.
  - `m_ack`→`ack`: 1 cycle.
  - `req` low and `m_ack` low → S_IDLE: 1 cycle.
- Minimum transaction is 3 cycles with zero-wait downstream. Back-to-back grants therefore have at least 1 idle cycle between them.
- `m_data` is valid for the whole S_REQ period and is combinational from `data_in`.

## Structure
- The shared package `hs_pkg` holds:
  - the state constants S_IDLE=0, S_REQ=1, S_ACK=2;
  - `HS_MAX_REQ`=8.
- One sub-module, `rr_pick`:
  - purely combinational;
  - inputs are `req[N]` and `ptr`;
  - outputs are `valid` and `idx[2:0]`;
  - implemented as a rotate, then a priority encoder, then an unrotate.
- Top level contains the FSM, the `grant_id`/`ptr`/`txn_count` registers, and the data mux.

## Test plan
- **Single requester:** `req`=4'b0100 with data 0xDEADBEEF, and `m_ack` returned 2 cycles after `m_req`.
  - `grant_id`=2.
  - `m_data`=0xDEADBEEF while `m_req` is high.
  - `ack`=4'b0100 until `req` drops.
  - `txn_count`=1.
- **Simultaneous requests:** `req`=4'b1111 held after reset. Grant order is 0,1,2,3,0, and no `ack` ever has two bits set.
- **Fairness:** requester 0 re-asserts immediately after every ack while requester 3 holds `req`. Requester 3 is served within 2 transactions and never starved.
- **Early drop:** requester 1 drops `req` in the cycle after `m_req` rises.
  - `m_req` stays high until `m_ack`.
  - `ack[1]` pulses.
  - The FSM returns to S_IDLE when `m_ack`=0.
- **Reset mid-op:** `rst` is asserted during S_ACK.
  - The next cycle shows `ack`=0, `m_req`=0, `busy`=0 and `txn_count`=0.
  - After release, the next grant starts from requester 0.
- **Counter wrap:** `txn_count` is forced to 0xFFFFFFFF and one transaction is completed. `txn_count` reads 0.
